// File: rtl/mem_stream_loader.sv
// mem_stream_loader: packs a byte stream little-endian into 32-bit words and writes them to
// consecutive on-chip RAM addresses. Define MEM_STREAM_LOADER_VERIFY_EN for readback verify.
module mem_stream_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 6049
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
`ifdef MEM_STREAM_LOADER_VERIFY_EN
    output logic              verify_err,
`endif
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    // One extra bit so a counter sitting at DEPTH never aliases a low address.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WRITE  = 3'd2,
        S_DRAIN  = 3'd3,
`ifdef MEM_STREAM_LOADER_VERIFY_EN
        S_VERIFY = 3'd5,
        S_CHECK  = 3'd6,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t            state_r, state_nx;
    logic [ADDR_W:0]   addr_r;
    logic [1:0]        lane_r;
    logic [3:0]        be_r, be_nx;
    logic [31:0]       pack_r, pack_nx;
    logic              last_r;
    logic [ADDR_W:0]   word_count_r;
    logic [31:0]       checksum_r;
    logic              done_r, overflow_r, busy_r, in_ready_r;
    logic              mem_cs_r, mem_wr_r, mem_clken_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wd_r;
    logic              accept_s, wr_ok_s;

`ifdef MEM_STREAM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_r;
    logic [3:0]        last_be_r;
    logic [ADDR_W:0]   rd_idx_r;
    logic              iss_r, iss_last_r, cap_r, cap_last_r;
    logic [31:0]       rb_sum_r;
    logic              verify_err_r;
    logic              rd_issue_s;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign rd_issue_s = (state_r == S_VERIFY) && (rd_idx_r < word_count_r);
`else
    logic unused_s;
    assign unused_s = ^mem_readdata;
`endif

    // Next-state decode and packing-buffer update for the accepted byte
    always_comb begin
        state_nx = state_r;
        accept_s = in_valid && in_ready_r;
        wr_ok_s  = (addr_r < DEPTH_C);
        pack_nx  = pack_r;
        be_nx    = be_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FILL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    pack_nx[{lane_r, 3'b000} +: 8] = in_data;
                    be_nx[lane_r]                 = 1'b1;
                    if ((lane_r == 2'd3) || in_last) begin
                        state_nx = S_WRITE;
                    end else begin
                        state_nx = S_FILL;
                    end
                end else begin
                    state_nx = S_FILL;
                end
            end
            S_WRITE: begin
                if (!last_r) begin
                    state_nx = wr_ok_s ? S_FILL : S_DRAIN;
                end else begin
`ifdef MEM_STREAM_LOADER_VERIFY_EN
                    state_nx = wr_ok_s ? S_VERIFY : S_DONE;
`else
                    state_nx = S_DONE;
`endif
                end
            end
            S_DRAIN: begin
                if (accept_s && in_last) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
`ifdef MEM_STREAM_LOADER_VERIFY_EN
            S_VERIFY: begin
                if ((rd_idx_r == word_count_r) && !iss_r && !cap_r) begin
                    state_nx = S_CHECK;
                end else begin
                    state_nx = S_VERIFY;
                end
            end
            S_CHECK: begin
                state_nx = S_DONE;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, packing buffer, address counter and load status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            addr_r       <= '0;
            lane_r       <= 2'd0;
            be_r         <= 4'd0;
            pack_r       <= 32'd0;
            last_r       <= 1'b0;
            word_count_r <= '0;
            checksum_r   <= 32'd0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nx;
            pack_r  <= pack_nx;
            be_r    <= be_nx;
            busy_r  <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            if (state_nx == S_DONE) begin
                done_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        addr_r       <= {1'b0, base_addr};
                        lane_r       <= 2'd0;
                        pack_r       <= 32'd0;
                        be_r         <= 4'd0;
                        last_r       <= 1'b0;
                        word_count_r <= '0;
                        checksum_r   <= 32'd0;
                        done_r       <= 1'b0;
                        overflow_r   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept_s) begin
                        lane_r <= lane_r + 2'd1;
                        last_r <= in_last;
                    end
                end
                S_WRITE: begin
                    lane_r <= 2'd0;
                    pack_r <= 32'd0;
                    be_r   <= 4'd0;
                    if (wr_ok_s) begin
                        addr_r       <= addr_r + ONE_C;
                        word_count_r <= word_count_r + ONE_C;
                        checksum_r   <= checksum_r + pack_r;
                    end else begin
                        overflow_r <= 1'b1;
                    end
                end
                default: begin
                    last_r <= last_r;
                end
            endcase
        end
    end

`ifdef MEM_STREAM_LOADER_VERIFY_EN
    // Readback pipeline: one read per cycle, data one cycle after the address, then compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r       <= '0;
            last_be_r    <= 4'd0;
            rd_idx_r     <= '0;
            iss_r        <= 1'b0;
            iss_last_r   <= 1'b0;
            cap_r        <= 1'b0;
            cap_last_r   <= 1'b0;
            rb_sum_r     <= 32'd0;
            verify_err_r <= 1'b0;
        end else begin
            iss_r      <= rd_issue_s;
            iss_last_r <= rd_issue_s && (rd_idx_r == (word_count_r - ONE_C));
            cap_r      <= iss_r;
            cap_last_r <= iss_last_r;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        base_r       <= base_addr;
                        verify_err_r <= 1'b0;
                    end
                end
                S_WRITE: begin
                    rd_idx_r <= '0;
                    rb_sum_r <= 32'd0;
                    if (wr_ok_s) begin
                        last_be_r <= be_r;
                    end
                end
                S_VERIFY: begin
                    if (rd_issue_s) begin
                        rd_idx_r <= rd_idx_r + ONE_C;
                    end
                    if (cap_r) begin
                        rb_sum_r <= rb_sum_r + (cap_last_r ? (mem_readdata & lane_mask(last_be_r))
                                                           : mem_readdata);
                    end
                end
                S_CHECK: begin
                    verify_err_r <= (rb_sum_r != checksum_r);
                end
                default: begin
                    rd_idx_r <= rd_idx_r;
                end
            endcase
        end
    end
`endif

    // Bus strobes and handshake, registered from the next-state decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r  <= 1'b0;
            mem_cs_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'd0;
            mem_wd_r    <= 32'd0;
            mem_clken_r <= 1'b1;
        end else begin
            in_ready_r  <= (state_nx == S_FILL) || (state_nx == S_DRAIN);
            mem_clken_r <= 1'b1;
            mem_cs_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'd0;
            mem_wd_r    <= 32'd0;
            if ((state_nx == S_WRITE) && wr_ok_s) begin
                mem_cs_r   <= 1'b1;
                mem_wr_r   <= 1'b1;
                mem_addr_r <= addr_r[ADDR_W-1:0];
                mem_be_r   <= be_nx;
                mem_wd_r   <= pack_nx;
            end
`ifdef MEM_STREAM_LOADER_VERIFY_EN
            else if (rd_issue_s) begin
                mem_cs_r   <= 1'b1;
                mem_addr_r <= base_r + rd_idx_r[ADDR_W-1:0];
                mem_be_r   <= 4'hF;
            end
`endif
        end
    end

    assign in_ready       = in_ready_r;
    assign mem_address    = mem_addr_r;
    assign mem_byteenable = mem_be_r;
    assign mem_chipselect = mem_cs_r;
    assign mem_write      = mem_wr_r;
    assign mem_writedata  = mem_wd_r;
    assign mem_clken      = mem_clken_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign overflow       = overflow_r;
    assign word_count     = word_count_r;
    assign checksum       = checksum_r;
`ifdef MEM_STREAM_LOADER_VERIFY_EN
    assign verify_err     = verify_err_r;
`endif

endmodule

// File: tb/tb_mem_stream_loader.sv
// Scoreboard bench for mem_stream_loader: a byte-image model predicts RAM writes and status;
// a negedge monitor pops expected writes as the DUT strobes them.
module tb_mem_stream_loader;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 6049;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b1;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        in_data   = 8'd0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic [31:0]       mem_readdata = 32'd0;
    logic              in_ready, mem_chipselect, mem_write, mem_clken;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata, checksum;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   word_count;

    mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  img_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_wc;
    logic [31:0] exp_sum;
    logic        exp_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    // Reference: chop the image into 4-byte words at base+i; stop at the first address past RAM.
    task automatic build_expect(input int base, input int max_push);
        int          nbytes;
        int          nwords;
        logic [31:0] d;
        logic [3:0]  be;
        wr_t         e;
        nbytes  = img_q.size();
        nwords  = (nbytes + 3) / 4;
        exp_wc  = 0;
        exp_sum = 32'd0;
        exp_ovf = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            d  = 32'd0;
            be = 4'd0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < nbytes) begin
                    d[8*b +: 8] = img_q[4*w + b];
                    be[b]       = 1'b1;
                end
            end
            if (base + w >= DEPTH) begin
                exp_ovf = 1'b1;
                break;
            end
            e.addr = ADDR_W'(base + w);
            e.data = d;
            e.be   = be;
            if (w < max_push) exp_q.push_back(e);
            exp_wc++;
            exp_sum += d;
        end
    endtask

    // Monitor: every RAM write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && mem_chipselect && mem_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h", mem_address, mem_writedata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_address), 64'(mon_e.addr));
                chk("wr_data", 64'(mem_writedata), 64'(mon_e.data));
                chk("wr_be", 64'(mem_byteenable), 64'(mon_e.be));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                timeout("in_ready");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input int base);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        in_valid  = 1'b1;
        in_data   = img_q[0];
        in_last   = (img_q.size() == 1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
    endtask

    task automatic send_all(input int gmin, input int gmax, input logic poke);
        int gap;
        for (int i = 0; i < img_q.size(); i++) begin
            gap = $urandom_range(gmax, gmin);
            if (i > 0 && gap > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 0) begin
                        start     = 1'b1;
                        base_addr = ADDR_W'($urandom);
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            send_byte(img_q[i], i == img_q.size() - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            timeout({tag, "_done"});
        end else begin
            chk({tag, "_wc"}, 64'(word_count), 64'(exp_wc));
            chk({tag, "_sum"}, 64'(checksum), 64'(exp_sum));
            chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input string tag, input int base, input int gmin, input int gmax,
                            input logic poke);
        build_expect(base, 1 << 30);
        begin_load(base);
        send_all(gmin, gmax, poke);
        finish_load(tag);
    endtask

    task automatic load_image(input logic [7:0] b[$]);
        img_q = b;
    endtask

    initial begin
        int base;
        int len;
        int sel;

        #1 reset_n = 1'b0;
        #20;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_sum", 64'(checksum), 64'd0);
        chk("rst_strobes", 64'({mem_chipselect, mem_write, mem_byteenable}), 64'd0);
        chk("rst_bus", 64'({mem_address, mem_writedata}), 64'd0);
        chk("rst_clken", 64'(mem_clken), 64'd1);
        #1 reset_n = 1'b1;

        load_image('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        run_load("t1", 'h10, 0, 0, 1'b0);
        chk("t1_sum_const", 64'(checksum), 64'hCCAA8866);
        chk("t1_done_sticky", 64'(done), 64'd1);

        load_image('{8'hAA, 8'hBB, 8'hCC});
        run_load("t2", 0, 0, 0, 1'b0);
        chk("t2_sum_const", 64'(checksum), 64'h00CCBBAA);

        img_q.delete();
        for (int i = 0; i < 12; i++) img_q.push_back(8'(i + 1));
        run_load("t3", DEPTH - 1, 0, 1, 1'b0);
        chk("t3_ovf_const", 64'(overflow), 64'd1);
        chk("t3_wc_const", 64'(word_count), 64'd1);

        // Reset while the second word is on the bus: only the first word may be seen
        img_q.delete();
        for (int i = 0; i < 8; i++) img_q.push_back(8'($urandom));
        build_expect('h100, 1);
        begin_load('h100);
        send_all(0, 0, 1'b0);
        chk("t4_wr_strobe", 64'(mem_write), 64'd1);
        chk("t4_wr_addr", 64'(mem_address), 64'h101);
        #1 reset_n = 1'b0;
        #1;
        chk("t4_strobes", 64'({mem_chipselect, mem_write}), 64'd0);
        chk("t4_status", 64'({busy, done, overflow, in_ready}), 64'd0);
        chk("t4_counts", 64'({word_count, checksum}), 64'd0);
        chk("t4_clken", 64'(mem_clken), 64'd1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        chk("t4_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        img_q.delete();
        for (int i = 0; i < 14; i++) img_q.push_back(8'($urandom));
        run_load("t5", 'h0200, 3, 3, 1'b1);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(3, 0);
            if (sel == 0) base = $urandom_range(DEPTH - 1, DEPTH - 6);
            else if (sel == 1) base = $urandom_range(8191, DEPTH);
            else base = $urandom_range(DEPTH - 1, 0);
            len = $urandom_range(24, 1);
            img_q.delete();
            for (int i = 0; i < len; i++) img_q.push_back(8'($urandom));
            run_load("rnd", base, 0, $urandom_range(3, 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
